// File: rtl/voltage_bcd_converter_if.sv
// ADC-to-display bus: sample/update inputs, BCD digits and status out.
// master drives samples and update requests; slave is the converter.
interface voltage_bcd_converter_if #(
  parameter int ADC_W  = 12,
  parameter int DIGITS = 3
);
  logic [ADC_W-1:0]    adc_data;
  logic                sample_valid;
  logic                update;
  logic [4*DIGITS-1:0] digits_out;
  logic                digits_valid;
  logic                busy;
  logic                overrange;

  modport master (
    output adc_data,
    output sample_valid,
    output update,
    input  digits_out,
    input  digits_valid,
    input  busy,
    input  overrange
  );

  modport slave (
    input  adc_data,
    input  sample_valid,
    input  update,
    output digits_out,
    output digits_valid,
    output busy,
    output overrange
  );
endinterface

// File: rtl/voltage_bcd_converter.sv
// Averages ADC codes, scales to mV by shift-add, converts to BCD digits.
// Ports: clk, rst_n (async low), bus (slave): samples in, digits/status out.
module voltage_bcd_converter #(
  parameter int ADC_W         = 12,
  parameter int FULL_SCALE_MV = 5000,
  parameter int CLAMP_CODE    = 2000,
  parameter int AVG_LOG2      = 2,
  parameter int DIGITS        = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  voltage_bcd_converter_if.slave bus
);

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int MV_W   = $clog2(FULL_SCALE_MV + 1);
  localparam int PROD_W = ADC_W + MV_W;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULT,
    S_BCD,
    S_DONE
  } state_t;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;
  logic [ADC_W-1:0]    avg;

  state_t              state;
  state_t              state_nxt;
  logic [5:0]          step;
  logic                clamp;
  logic                mult_last;
  logic                bcd_last;

  logic [ADC_W-1:0]    mplier;
  logic [PROD_W-1:0]   mcand;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   prod_nxt;
  logic [15:0]         mv_mult;
  logic [31:0]         dd;
  logic [31:0]         dd_adj;
  logic [31:0]         dd_nxt;
  logic                ovr_pend;
  logic [4*DIGITS-1:0] digits_q;
  logic                ovr_q;

  // Averager runs regardless of converter state.
  assign sum = acc + ACC_W'(bus.adc_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
    end else if (bus.sample_valid) begin
      if (cnt == LAST) begin
        acc <= '0;
        cnt <= '0;
        avg <= ADC_W'(sum >> AVG_LOG2);
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign clamp     = 32'(avg) > 32'(CLAMP_CODE);
  assign mult_last = step == 6'(ADC_W - 1);
  assign bcd_last  = step == 6'd15;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (bus.update) state_nxt = S_LOAD;
      S_LOAD: state_nxt = clamp ? S_BCD : S_MULT;
      S_MULT: if (mult_last) state_nxt = S_BCD;
      S_BCD:  if (bcd_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Final partial product is folded in so mv is ready on the last edge.
  assign prod_nxt = mplier[0] ? prod + mcand : prod;
  assign mv_mult  = 16'(prod_nxt >> (ADC_W - 1));

  // Double-dabble: +3 on nibbles >= 5, then shift left.
  always_comb begin
    dd_adj = dd;
    for (int i = 0; i < 4; i++) begin
      if (dd[16+4*i +: 4] > 4'd4)
        dd_adj[16+4*i +: 4] = dd[16+4*i +: 4] + 4'd3;
    end
  end

  assign dd_nxt = dd_adj << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= '0;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      dd       <= '0;
      ovr_pend <= 1'b0;
      digits_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_LOAD: begin
          step     <= '0;
          ovr_pend <= clamp;
          mplier   <= avg;
          mcand    <= PROD_W'(FULL_SCALE_MV);
          prod     <= '0;
          dd       <= {16'd0, 16'(FULL_SCALE_MV)};
        end
        S_MULT: begin
          prod   <= prod_nxt;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          step   <= mult_last ? '0 : step + 6'd1;
          if (mult_last) dd <= {16'd0, mv_mult};
        end
        S_BCD: begin
          dd   <= dd_nxt;
          step <= step + 6'd1;
          if (bcd_last) begin
            digits_q <= dd_nxt[31 -: 4*DIGITS];
            ovr_q    <= ovr_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.digits_out   = digits_q;
  assign bus.overrange    = ovr_q;
  assign bus.digits_valid = state == S_DONE;
  assign bus.busy         = state != S_IDLE;

endmodule

// File: tb/tb_voltage_bcd_converter.sv
// Scoreboard bench for voltage_bcd_converter: three parameterisations,
// directed samples, expected digits queued at update time.
module tb_voltage_bcd_converter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  voltage_bcd_converter_if #(.ADC_W(12), .DIGITS(3)) ifa ();
  voltage_bcd_converter_if #(.ADC_W(12), .DIGITS(3)) ifb ();
  voltage_bcd_converter_if #(.ADC_W(12), .DIGITS(4)) ifc ();

  voltage_bcd_converter #(.AVG_LOG2(0), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  voltage_bcd_converter #(.AVG_LOG2(2), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );
  voltage_bcd_converter #(.AVG_LOG2(0), .DIGITS(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  // dut_a and dut_c share stimulus
  logic [11:0] adc;
  logic        sv;
  logic        upd;

  assign ifa.adc_data     = adc;
  assign ifa.sample_valid = sv;
  assign ifa.update       = upd;
  assign ifc.adc_data     = adc;
  assign ifc.sample_valid = sv;
  assign ifc.update       = upd;

  typedef struct {
    logic [15:0] dig;
    logic        ovr;
    int          issue;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic score(input int id,
                       input logic [15:0] dig,
                       input logic ovr);
    exp_t e;
    int   n;
    n = (id == 0) ? qa.size() : (id == 1) ? qb.size() : qc.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_valid dut%0d: got %0h want none", id, dig);
      return;
    end
    case (id)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    check($sformatf("digits_dut%0d", id), 32'(dig), 32'(e.dig));
    check($sformatf("ovr_dut%0d", id), 32'(ovr), 32'(e.ovr));
    check($sformatf("latency_dut%0d", id), cyc - e.issue, e.lat);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.digits_valid) score(0, 16'(ifa.digits_out), ifa.overrange);
      if (ifb.digits_valid) score(1, 16'(ifb.digits_out), ifb.overrange);
      if (ifc.digits_valid) score(2, 16'(ifc.digits_out), ifc.overrange);
    end
  end

  task automatic sample_a(input logic [11:0] v);
    adc = v;
    sv  = 1'b1;
    @(negedge clk);
    sv  = 1'b0;
  endtask

  task automatic sample_b(input logic [11:0] v);
    ifb.adc_data     = v;
    ifb.sample_valid = 1'b1;
    @(negedge clk);
    ifb.sample_valid = 1'b0;
  endtask

  task automatic trig_a(input logic [11:0] da, input logic [15:0] dc,
                        input logic ovr, input int lat, input bit push);
    upd = 1'b1;
    if (push) begin
      qa.push_back('{16'(da), ovr, cyc, lat});
      qc.push_back('{dc, ovr, cyc, lat});
    end
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic trig_b(input logic [11:0] db);
    ifb.update = 1'b1;
    qb.push_back('{16'(db), 1'b0, cyc, 30});
    @(negedge clk);
    ifb.update = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifa.busy || ifb.busy || ifc.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic conv_a(input logic [11:0] v, input logic [11:0] da,
                        input logic [15:0] dc, input logic ovr,
                        input int lat);
    sample_a(v);
    trig_a(da, dc, ovr, lat, 1'b1);
    check("busy_rise", 32'(ifa.busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    adc = '0;
    sv  = 1'b0;
    upd = 1'b0;
    ifb.adc_data     = '0;
    ifb.sample_valid = 1'b0;
    ifb.update       = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_digits", 32'(ifa.digits_out), 32'd0);
    check("rst_valid", 32'(ifa.digits_valid), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_ovr", 32'(ifa.overrange), 32'd0);
    check("rst_digits_c", 32'(ifc.digits_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    conv_a(12'd1024, 12'h250, 16'h2500, 1'b0, 30);
    conv_a(12'd2000, 12'h488, 16'h4882, 1'b0, 30);
    conv_a(12'd1,    12'h000, 16'h0002, 1'b0, 30);
    conv_a(12'd2001, 12'h500, 16'h5000, 1'b1, 18);
    conv_a(12'd4095, 12'h500, 16'h5000, 1'b1, 18);
    conv_a(12'd1024, 12'h250, 16'h2500, 1'b0, 30);

    // second update inside MULT must be dropped
    sample_a(12'd2000);
    trig_a(12'h488, 16'h4882, 1'b0, 30, 1'b1);
    repeat (5) @(negedge clk);
    trig_a(12'h000, 16'h0000, 1'b0, 0, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);
    check("no_retrigger_busy", 32'(ifa.busy), 32'd0);

    // averaging window of four
    sample_b(12'd1000);
    sample_b(12'd1000);
    sample_b(12'd1048);
    sample_b(12'd1048);
    trig_b(12'h250);
    wait_idle();
    sample_b(12'd2000);
    sample_b(12'd2000);
    sample_b(12'd2000);
    trig_b(12'h250);
    repeat (18) @(negedge clk);
    sample_b(12'd2000);
    wait_idle();
    trig_b(12'h488);
    wait_idle();

    // reset during BCD aborts without a strobe
    sample_a(12'd1024);
    trig_a(12'h000, 16'h0000, 1'b0, 0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_digits", 32'(ifa.digits_out), 32'd0);
    check("abort_busy", 32'(ifa.busy), 32'd0);
    check("abort_valid", 32'(ifa.digits_valid), 32'd0);
    check("abort_digits_c", 32'(ifc.digits_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", 32'(ifa.busy), 32'd0);

    conv_a(12'd1024, 12'h250, 16'h2500, 1'b0, 30);

    check("sb_empty", qa.size() + qb.size() + qc.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
